// File: rtl/cpipe2_issue.sv
// Stage-2 control-word issue stage: a 2-entry skid FIFO feeding the registered cpipe2s
// word, with bubble insertion for load-use, return shadow, downstream stall and flush.
module cpipe2_issue #(
  parameter int LOAD_BUBBLES = 1,
  parameter int RET_SHADOW   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_word,
  input  logic       stall,
  input  logic       flush,
  output logic [7:0] cpipe2s,
  output logic       cpipe2s_valid,
  output logic       busy
);

  localparam logic [7:0] BUBBLE   = 8'h20;
  localparam logic [1:0] LOAD_CNT = LOAD_BUBBLES[1:0];
  localparam logic [1:0] RET_CNT  = RET_SHADOW[1:0];

  // Handshake: a word transfers on any cycle where in_valid and in_ready are both high;
  // in_ready comes from the registered FIFO count only, never from stall or flush.

  logic [7:0] mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic [1:0] load_wait;
  logic [1:0] shadow;

  logic       push;
  logic       advance;
  logic       fifo_empty;
  logic       head_avail;
  logic [7:0] head_raw;
  logic [7:0] head_word;
  logic       head_is_load;
  logic       head_is_ret;
  logic       consume;
  logic       fifo_pop;
  logic       fifo_write;

  logic [7:0] stage_next;
  logic       valid_next;
  logic [1:0] load_wait_next;
  logic [1:0] shadow_next;
  logic [1:0] count_next;

  assign in_ready   = (count != 2'd2);
  assign push       = in_valid & in_ready;
  assign advance    = ~stall | flush;
  assign fifo_empty = (count == 2'd0);

  // With an empty FIFO the incoming word is the head candidate (bypass path).
  assign head_avail = ~fifo_empty | push;
  assign head_raw   = fifo_empty ? in_word : mem[rd_ptr];
  assign head_word  = head_raw & 8'hBF;

  assign head_is_load = head_word[7] & head_word[5] & head_word[4] & (head_word[3:0] == 4'h0);
  assign head_is_ret  = head_word[7] & head_word[3] & head_word[1] & ~head_word[5] & ~head_word[4];

  // The head is consumed when it issues or when the return shadow discards it;
  // the load-wait bubble leaves it in place.
  assign consume    = advance & ~flush & head_avail & ((shadow != 2'd0) | (load_wait == 2'd0));
  assign fifo_pop   = consume & ~fifo_empty;
  assign fifo_write = push & ~flush & ~(consume & fifo_empty);

  always_comb begin
    stage_next     = cpipe2s;
    valid_next     = cpipe2s_valid;
    load_wait_next = load_wait;
    shadow_next    = shadow;
    if (advance) begin
      stage_next = BUBBLE;
      valid_next = 1'b0;
      if (flush) begin
        load_wait_next = 2'd0;
        shadow_next    = 2'd0;
      end else if (shadow != 2'd0) begin
        shadow_next = shadow - 2'd1;
      end else if (load_wait != 2'd0) begin
        load_wait_next = load_wait - 2'd1;
      end else if (head_avail) begin
        stage_next = head_word;
        valid_next = 1'b1;
        if (head_is_load) load_wait_next = LOAD_CNT;
        if (head_is_ret)  shadow_next    = RET_CNT;
      end
    end
  end

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else if (fifo_write && !fifo_pop) begin
      count_next = count + 2'd1;
    end else if (!fifo_write && fifo_pop) begin
      count_next = count - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpipe2s       <= BUBBLE;
      cpipe2s_valid <= 1'b0;
      load_wait     <= 2'd0;
      shadow        <= 2'd0;
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
    end else begin
      cpipe2s       <= stage_next;
      cpipe2s_valid <= valid_next;
      load_wait     <= load_wait_next;
      shadow        <= shadow_next;
      count         <= count_next;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (fifo_pop)   rd_ptr <= ~rd_ptr;
        if (fifo_write) wr_ptr <= ~wr_ptr;
      end
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (fifo_write) mem[wr_ptr] <= in_word;
  end

  assign busy = (load_wait != 2'd0) | (shadow != 2'd0);

endmodule

// File: doc/cpipe2_issue.md
# cpipe2_issue

Stage-2 control-word issue stage for the CPIPE2s pipeline. It accepts encoded stage-2 control words from the upstream decode/issue logic over a valid/ready handshake and buffers them in a 2-entry skid FIFO. It drives the registered `cpipe2s` word consumed by the stage-2 control decoders, and inserts bubbles for load-use and return-shadow hazards, downstream stalls and flushes.

## Interface
Parameters:
- `LOAD_BUBBLES`, default 1: bubbles inserted after a LOAD word issues. Legal range 0–3.
- `RET_SHADOW`, default 2: cycles of squash after a return word issues. Legal range 0–3.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  FIFO can accept a word; equals (FIFO count < 2).
- `in_word`  in  8  encoded control word; bit 6 is ignored.
- `stall`  in  1  downstream hold.
- `flush`  in  1  squash all pending and in-flight words.
- `cpipe2s`  out  8  registered stage-2 control word. Bit 6 is always 0.
- `cpipe2s_valid`  out  1  `cpipe2s` holds an issued word rather than a bubble.
- `busy`  out  1  the load-wait counter or the shadow counter is nonzero.

## Operation
- BUBBLE word: 8'h20 (bit 7 = 0, bit 5 = 1). It decodes to all-zero controls downstream.
- LOAD class: bits {7,5,4} = 1 and bits {3,2,1,0} = 0, i.e. 8'hB0 with bit 6 masked.
- RETURN class: bits 7, 3 and 1 = 1; bits 5 and 4 = 0.
- Accept: a transfer occurs when `in_valid & in_ready`.
- Bypass: if the FIFO is empty and the stage advances this cycle, an accepted word goes straight into `cpipe2s` and is not written to the FIFO.
- Otherwise the accepted word is written to the FIFO tail.
- Head: the FIFO head if the FIFO is non-empty, else the bypassed `in_word`.
- Advance: occurs when `stall` = 0 or `flush` = 1. On advance, the stage register is loaded by priority (first match wins):
  1. `flush`: load BUBBLE. Empty the FIFO, clear both counters, and discard any word accepted this cycle.
  2. Shadow counter > 0: load BUBBLE, pop and discard the head if one exists, decrement shadow.
  3. Load-wait counter > 0: load BUBBLE, decrement load-wait. The FIFO is not popped.
  4. Head available: load head with bit 6 forced to 0, pop it, set `cpipe2s_valid` = 1.
     - LOAD class: load-wait counter ← `LOAD_BUBBLES`.
     - RETURN class: shadow counter ← `RET_SHADOW`.
  5. Otherwise: load BUBBLE and set `cpipe2s_valid` = 0.
- `cpipe2s_valid` = 0 whenever BUBBLE is loaded through cases 1–3 or 5.
- Stall without flush:
  - `cpipe2s`, `cpipe2s_valid` and both counters hold.
  - The FIFO still accepts words until it is full; there is no bypass.
- Simultaneous push and pop on a full FIFO is not possible, because `in_ready` = 0 when the FIFO is full.
- Simultaneous push and pop at count 1 leaves the count at 1.

## Timing
- Reset (async) values:
  - `cpipe2s` = 8'h20, `cpipe2s_valid` = 0, `busy` = 0.
  - FIFO empty, so `in_ready` = 1.
  - Both counters = 0.
- Latency: a word accepted in cycle N with an empty FIFO, no stall and no hazard appears on `cpipe2s` in cycle N+1.
- Throughput: 1 word per cycle sustained with no hazards.
- Load-use: LOAD visible in cycle N → `LOAD_BUBBLES` bubbles in cycles N+1 … N+`LOAD_BUBBLES` → next word in the following cycle.
- Return: RETURN visible in cycle N → cycles N+1 … N+`RET_SHADOW` show BUBBLE. Any words popped during those cycles are lost.
- `in_ready` is derived from registered FIFO count only. It is never combinationally dependent on `stall` or `flush`.
- Reset mid-operation: all state returns to the reset values immediately. In-flight words are lost.
- Flush during stall: takes effect at that edge (flush overrides stall).

## Test plan
- Reset then idle: `cpipe2s` = 8'h20, `cpipe2s_valid` = 0, `in_ready` = 1. Push 8'h8A → next cycle `cpipe2s` = 8'h8A, `cpipe2s_valid` = 1.
- Load-use, `LOAD_BUBBLES` = 1: push 8'hB0, then 8'h91 back-to-back → `cpipe2s` sequence B0, 20, 91. `in_ready` stays 1 and the FIFO count peaks at 1.
- Return shadow, `RET_SHADOW` = 2: push 8'h8A, 8'h81, 8'h82, 8'h84 → outputs 8A, 20, 20, 84. Words 81 and 82 are discarded.
- Stall fill: `stall` = 1 for 4 cycles while pushing 8'h81, 8'h82, 8'h83 → the first two are accepted, `in_ready` = 0, `cpipe2s` holds. Release stall → 81, 82 issue in order, then 83 is accepted.
- Flush: FIFO holding 2 words with load-wait = 1, assert `flush` with `stall` = 1 → next cycle `cpipe2s` = 8'h20, `busy` = 0, `in_ready` = 1, and no stale word ever issues.
- Bit-6 masking and async reset: push 8'hF0 → `cpipe2s` = 8'hB0 (treated as LOAD). Assert `reset` mid-bubble → outputs return to reset values before the next clock edge.
